// File: rtl/fifo_mem_ctrl.sv
// Single-clock sequencer for one fifo_mem instance: pointers, enables, occupancy flags,
// and a first-word-fall-through valid/ready view of the registered memory output.
module fifo_mem_ctrl #(
  parameter int ADDR     = 6,
  parameter int AF_LEVEL = 2**ADDR - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            winc,
  output logic            full,
  output logic            almost_full,
  output logic            wclken,
  output logic [ADDR-1:0] waddr,
  input  logic            rready,
  output logic            rvalid,
  output logic            rclken,
  output logic [ADDR-1:0] raddr,
  output logic            almost_empty,
  output logic [ADDR:0]   occupancy,
  output logic            overflow,
  input  logic            err_clr
);

  localparam logic [ADDR:0] DEPTH = (ADDR+1)'(2**ADDR);
  localparam logic [ADDR:0] AF_TH = (ADDR+1)'(AF_LEVEL);
  localparam logic [ADDR:0] AE_TH = (ADDR+1)'(AE_LEVEL);

  logic [ADDR-1:0] wptr;
  logic [ADDR-1:0] rptr;
  // Words sitting in the memory array; the word already loaded into rdata is tracked by rvalid.
  logic [ADDR:0]   mem_cnt;

  assign full         = (mem_cnt == DEPTH);
  assign wclken       = winc & ~full & ~flush;
  // Prefetch whenever the output slot is free or being emptied this cycle.
  assign rclken       = (mem_cnt != '0) & (~rvalid | rready) & ~flush;
  assign waddr        = wptr;
  assign raddr        = rptr;
  assign occupancy    = mem_cnt + (ADDR+1)'(rvalid);
  assign almost_full  = (occupancy >= AF_TH);
  assign almost_empty = (occupancy <= AE_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      rvalid  <= 1'b0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      mem_cnt <= '0;
      rvalid  <= 1'b0;
    end else begin
      if (wclken) wptr <= wptr + 1'b1;
      if (rclken) rptr <= rptr + 1'b1;
      case ({wclken, rclken})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
      if (rclken)
        rvalid <= 1'b1;
      else if (rready & rvalid)
        rvalid <= 1'b0;
    end
  end

  // Sticky error: a set in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (winc & full & ~flush)
      overflow <= 1'b1;
    else if (err_clr)
      overflow <= 1'b0;
  end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed bench for fifo_mem_ctrl (ADDR=2) with a small behavioural fifo_mem model
// providing the registered rdata path.
module tb_fifo_mem_ctrl;
  localparam int ADDR = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            winc = 1'b0;
  logic            rready = 1'b0;
  logic            err_clr = 1'b0;
  logic [7:0]      wdata = 8'h00;
  logic            full, almost_full, wclken, rvalid, rclken, almost_empty, overflow;
  logic [ADDR-1:0] waddr, raddr;
  logic [ADDR:0]   occupancy;

  logic [7:0] mem [4];
  logic [7:0] rdata;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fifo_mem_ctrl #(.ADDR(ADDR), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .full(full),
    .almost_full(almost_full), .wclken(wclken), .waddr(waddr), .rready(rready),
    .rvalid(rvalid), .rclken(rclken), .raddr(raddr), .almost_empty(almost_empty),
    .occupancy(occupancy), .overflow(overflow), .err_clr(err_clr)
  );

  always @(posedge clk) begin
    if (wclken) mem[waddr] <= wdata;
    if (rclken) rdata <= mem[raddr];
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; winc = 1'b0; rready = 1'b0; err_clr = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Stimulus only: five writes 0x01..0x05 with rready low, then a sixth that overflows.
  task automatic fill_and_overflow();
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1; wdata = 8'(i + 1);
      step();
    end
    step();
    winc = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #1;
    total++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got=%0h want=0", rvalid); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got=%0h want=0", full); else passed++;
    total++; if (almost_full !== 1'b0) $display("FAIL reset_af got=%0h want=0", almost_full); else passed++;
    total++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got=%0h want=1", almost_empty); else passed++;
    total++; if (occupancy !== 3'd0) $display("FAIL reset_occ got=%0d want=0", occupancy); else passed++;
    total++; if (wclken !== 1'b0 || rclken !== 1'b0) $display("FAIL reset_en got=%0h%0h want=00", wclken, rclken); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%0h want=0", overflow); else passed++;
  endtask

  task automatic test_single_write();
    do_reset();
    winc = 1'b1; wdata = 8'hA5; #1;
    total++; if (wclken !== 1'b1 || waddr !== 2'd0) $display("FAIL sw_wen got=%0h/%0d want=1/0", wclken, waddr); else passed++;
    total++; if (rclken !== 1'b0) $display("FAIL sw_ren_early got=%0h want=0", rclken); else passed++;
    step();
    winc = 1'b0; #1;
    total++; if (rclken !== 1'b1 || raddr !== 2'd0) $display("FAIL sw_ren got=%0h/%0d want=1/0", rclken, raddr); else passed++;
    total++; if (rvalid !== 1'b0) $display("FAIL sw_rvalid_early got=%0h want=0", rvalid); else passed++;
    step();
    total++; if (rvalid !== 1'b1 || rdata !== 8'hA5) $display("FAIL sw_out got=%0h/%0h want=1/a5", rvalid, rdata); else passed++;
    total++; if (occupancy !== 3'd1 || almost_empty !== 1'b1) $display("FAIL sw_occ got=%0d/%0h want=1/1", occupancy, almost_empty); else passed++;
    rready = 1'b1;
    step();
    rready = 1'b0;
    total++; if (rvalid !== 1'b0 || occupancy !== 3'd0) $display("FAIL sw_consume got=%0h/%0d want=0/0", rvalid, occupancy); else passed++;
  endtask

  task automatic test_fill_overflow();
    logic [2:0] exp_occ [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic       exp_af  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_ful [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1; wdata = 8'(i + 1); #1;
      total++; if (wclken !== 1'b1) $display("FAIL fill_wen%0d got=%0h want=1", i, wclken); else passed++;
      step();
      total++; if (occupancy !== exp_occ[i]) $display("FAIL fill_occ%0d got=%0d want=%0d", i, occupancy, exp_occ[i]); else passed++;
      total++; if (almost_full !== exp_af[i]) $display("FAIL fill_af%0d got=%0h want=%0h", i, almost_full, exp_af[i]); else passed++;
      total++; if (full !== exp_ful[i]) $display("FAIL fill_full%0d got=%0h want=%0h", i, full, exp_ful[i]); else passed++;
    end
    wdata = 8'hFF; #1;
    total++; if (wclken !== 1'b0) $display("FAIL ovf_wen got=%0h want=0", wclken); else passed++;
    step();
    winc = 1'b0;
    total++; if (overflow !== 1'b1 || occupancy !== 3'd5) $display("FAIL ovf_set got=%0h/%0d want=1/5", overflow, occupancy); else passed++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clr got=%0h want=0", overflow); else passed++;
  endtask

  // Continues from the full state left by test_fill_overflow.
  task automatic test_drain();
    logic [1:0] exp_raddr [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    rready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (rvalid !== 1'b1 || rdata !== 8'(k + 1)) $display("FAIL drain_data%0d got=%0h/%0h want=1/%0h", k, rvalid, rdata, k + 1); else passed++;
      if (k < 4) begin
        total++; if (rclken !== 1'b1 || raddr !== exp_raddr[k]) $display("FAIL drain_raddr%0d got=%0h/%0d want=1/%0d", k, rclken, raddr, exp_raddr[k]); else passed++;
      end
      step();
    end
    rready = 1'b0;
    total++; if (rvalid !== 1'b0 || occupancy !== 3'd0 || almost_empty !== 1'b1) $display("FAIL drain_end got=%0h/%0d/%0h want=0/0/1", rvalid, occupancy, almost_empty); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    rready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      winc = 1'b1; wdata = 8'(8'h10 + i);
      step();
      if (i >= 1) begin
        total++; if (rvalid !== 1'b1 || rdata !== 8'(8'h10 + i - 1)) $display("FAIL b2b_data%0d got=%0h/%0h want=1/%0h", i, rvalid, rdata, 8'h10 + i - 1); else passed++;
        total++; if (occupancy !== 3'd2) $display("FAIL b2b_occ%0d got=%0d want=2", i, occupancy); else passed++;
      end
    end
    winc = 1'b0;
    total++; if (waddr !== 2'd0) $display("FAIL b2b_wptr got=%0d want=0", waddr); else passed++;
    step();
    total++; if (rvalid !== 1'b1 || rdata !== 8'h1B) $display("FAIL b2b_last got=%0h/%0h want=1/1b", rvalid, rdata); else passed++;
    step();
    rready = 1'b0;
    total++; if (rvalid !== 1'b0 || occupancy !== 3'd0) $display("FAIL b2b_empty got=%0h/%0d want=0/0", rvalid, occupancy); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    fill_and_overflow();
    rready = 1'b1;
    step(); step();
    rready = 1'b0;
    total++; if (occupancy !== 3'd3 || rdata !== 8'h03) $display("FAIL fl_pre got=%0d/%0h want=3/03", occupancy, rdata); else passed++;
    flush = 1'b1; winc = 1'b1; wdata = 8'hEE; #1;
    total++; if (wclken !== 1'b0 || rclken !== 1'b0) $display("FAIL fl_en got=%0h%0h want=00", wclken, rclken); else passed++;
    step();
    flush = 1'b0; winc = 1'b0;
    total++; if (occupancy !== 3'd0 || rvalid !== 1'b0) $display("FAIL fl_clear got=%0d/%0h want=0/0", occupancy, rvalid); else passed++;
    total++; if (waddr !== 2'd0 || raddr !== 2'd0) $display("FAIL fl_ptr got=%0d/%0d want=0/0", waddr, raddr); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL fl_ovf got=%0h want=1", overflow); else passed++;
    winc = 1'b1; wdata = 8'h3C;
    step();
    winc = 1'b0;
    step();
    total++; if (rvalid !== 1'b1 || rdata !== 8'h3C) $display("FAIL fl_first got=%0h/%0h want=1/3c", rvalid, rdata); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    fill_and_overflow();
    #2; rst_n = 1'b0; #1;
    total++; if (rvalid !== 1'b0 || full !== 1'b0) $display("FAIL ar_flags got=%0h/%0h want=0/0", rvalid, full); else passed++;
    total++; if (occupancy !== 3'd0 || overflow !== 1'b0) $display("FAIL ar_state got=%0d/%0h want=0/0", occupancy, overflow); else passed++;
    step();
    rst_n = 1'b1;
    winc = 1'b1; wdata = 8'h77;
    step();
    winc = 1'b0;
    total++; if (rvalid !== 1'b0) $display("FAIL ar_lat1 got=%0h want=0", rvalid); else passed++;
    step();
    total++; if (rvalid !== 1'b1 || rdata !== 8'h77) $display("FAIL ar_lat2 got=%0h/%0h want=1/77", rvalid, rdata); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_drain();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
